// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the three-port SRAM arbiter.
// Imported by sram_arbiter and sram_arb_rr_pick.
package sram_arb_pkg;

    typedef enum logic {
        S_ARB_IDLE,
        S_ARB_LOCKED
    } arb_state_t;

    localparam logic [1:0] ARB_PORT_UART = 2'd0;
    localparam logic [1:0] ARB_PORT_DEC  = 2'd1;
    localparam logic [1:0] ARB_PORT_VGA  = 2'd2;

    localparam int ARB_ADDR_W       = 18;
    localparam int ARB_DATA_W       = 16;
    localparam int ARB_READ_LATENCY = 2;
    localparam int ARB_LOCK_MAX     = 64;

    function automatic logic [2:0] port_onehot(input logic [1:0] port);
        case (port)
            ARB_PORT_UART: return 3'b001;
            ARB_PORT_DEC:  return 3'b010;
            ARB_PORT_VGA:  return 3'b100;
            default:       return 3'b000;
        endcase
    endfunction

    function automatic logic [1:0] onehot_to_idx(input logic [2:0] onehot);
        if (onehot[2]) return ARB_PORT_VGA;
        if (onehot[1]) return ARB_PORT_DEC;
        return ARB_PORT_UART;
    endfunction

endpackage

// File: rtl/sram_arb_rr_pick.sv
// Round-robin priority encoder for three requesters.
// The search starts at the port after the last grant, wrapping from 2 to 0.
module sram_arb_rr_pick
    import sram_arb_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] last,
    output logic [2:0] gnt
);

    always_comb begin
        gnt = 3'b000;
        case (last)
            ARB_PORT_UART: gnt = req[1] ? 3'b010 : req[2] ? 3'b100 : req[0] ? 3'b001 : 3'b000;
            ARB_PORT_DEC:  gnt = req[2] ? 3'b100 : req[0] ? 3'b001 : req[1] ? 3'b010 : 3'b000;
            default:       gnt = req[0] ? 3'b001 : req[1] ? 3'b010 : req[2] ? 3'b100 : 3'b000;
        endcase
    end

endmodule

// File: rtl/sram_arbiter.sv
// Three-port SRAM arbiter with round-robin arbitration, burst locking and tagged read return.
// Define SRAM_ARB_VGA_PRIORITY_EN to give port 2 (VGA) absolute priority, even over a lock.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W       = ARB_ADDR_W,
    parameter int DATA_W       = ARB_DATA_W,
    parameter int READ_LATENCY = ARB_READ_LATENCY,
    parameter int LOCK_MAX     = ARB_LOCK_MAX
) (
    input  logic                Clock_50,
    input  logic                Resetn,
    input  logic [2:0]          req_i,
    input  logic [2:0]          we_i,
    input  logic [2:0]          lock_i,
    input  logic [3*ADDR_W-1:0] addr_i,
    input  logic [3*DATA_W-1:0] wdata_i,
    output logic [2:0]          gnt_o,
    output logic [2:0]          rvalid_o,
    output logic [DATA_W-1:0]   rdata_o,
    output logic [1:0]          owner_o,
    output logic [ADDR_W-1:0]   SRAM_address_o,
    output logic [DATA_W-1:0]   SRAM_write_data_o,
    output logic                SRAM_we_n_o,
    input  logic [DATA_W-1:0]   SRAM_read_data_i
);

    localparam int CNT_W = (LOCK_MAX > 2) ? $clog2(LOCK_MAX) : 1;

    arb_state_t        state;
    logic [1:0]        last_grant;
    logic [1:0]        owner;
    logic [CNT_W-1:0]  lock_cnt;
    logic [2:0]        rr_gnt;
    logic [2:0]        gnt;
    logic [1:0]        gnt_idx;
    logic              gnt_any;
    logic              lock_hold;
    logic              preempt;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_we;
    logic [2:0]        rd_cmd;
    logic [2:0]        rd_pipe [READ_LATENCY];

    sram_arb_rr_pick u_rr_pick (
        .req  (req_i),
        .last (last_grant),
        .gnt  (rr_gnt)
    );

    // A lock is only honoured while its owner keeps lock_i high; dropping it hands back to round-robin at once.
    assign lock_hold = (state == S_ARB_LOCKED) && lock_i[owner];

    always_comb begin
        gnt = rr_gnt;
        if (lock_hold) begin
            gnt = req_i[owner] ? port_onehot(owner) : 3'b000;
        end
`ifdef SRAM_ARB_VGA_PRIORITY_EN
        if (req_i[ARB_PORT_VGA]) begin
            gnt = 3'b100;
        end
`endif
    end

    assign gnt_o   = Resetn ? gnt : 3'b000;
    assign gnt_any = |gnt;
    assign gnt_idx = onehot_to_idx(gnt);
    assign preempt = lock_hold && gnt[ARB_PORT_VGA] && (owner != ARB_PORT_VGA);
    assign rdata_o = SRAM_read_data_i;

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_we    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (gnt[i]) begin
                sel_addr  = addr_i[i*ADDR_W +: ADDR_W];
                sel_wdata = wdata_i[i*DATA_W +: DATA_W];
                sel_we    = we_i[i];
            end
        end
    end

    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            state             <= S_ARB_IDLE;
            last_grant        <= ARB_PORT_VGA;
            owner             <= ARB_PORT_UART;
            owner_o           <= ARB_PORT_UART;
            lock_cnt          <= '0;
            SRAM_address_o    <= '0;
            SRAM_write_data_o <= '0;
            SRAM_we_n_o       <= 1'b1;
        end else begin
            if (gnt_any) begin
                last_grant        <= gnt_idx;
                owner_o           <= gnt_idx;
                SRAM_address_o    <= sel_addr;
                SRAM_write_data_o <= sel_wdata;
                SRAM_we_n_o       <= ~sel_we;
            end else begin
                SRAM_we_n_o <= 1'b1;
            end

            case (state)
                S_ARB_IDLE: begin
                    if (gnt_any && lock_i[gnt_idx]) begin
                        state    <= S_ARB_LOCKED;
                        owner    <= gnt_idx;
                        lock_cnt <= '0;
                    end
                end
                S_ARB_LOCKED: begin
                    if (!lock_hold) begin
                        state    <= S_ARB_IDLE;
                        lock_cnt <= '0;
                        if (gnt_any && lock_i[gnt_idx]) begin
                            state <= S_ARB_LOCKED;
                            owner <= gnt_idx;
                        end
                    end else if (preempt) begin
                        state <= S_ARB_LOCKED;
                    end else if (lock_cnt == CNT_W'(LOCK_MAX - 2)) begin
                        // Forced release: the owner drops to lowest round-robin priority.
                        state      <= S_ARB_IDLE;
                        lock_cnt   <= '0;
                        last_grant <= owner;
                    end else begin
                        lock_cnt <= lock_cnt + 1'b1;
                    end
                end
                default: state <= S_ARB_IDLE;
            endcase
        end
    end

    // rd_cmd tags the cycle SRAM_address_o carries a read; the pipe then delays that tag by the SRAM latency.
    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            rd_cmd <= 3'b000;
            for (int i = 0; i < READ_LATENCY; i++) begin
                rd_pipe[i] <= 3'b000;
            end
        end else begin
            rd_cmd     <= (gnt_any && !sel_we) ? gnt : 3'b000;
            rd_pipe[0] <= rd_cmd;
            for (int i = 1; i < READ_LATENCY; i++) begin
                rd_pipe[i] <= rd_pipe[i-1];
            end
        end
    end

    assign rvalid_o = rd_pipe[READ_LATENCY-1];

endmodule
